gru_hidden_update: RTL and testbench
====================================

GRU_HIDDEN_UPDATE -- requirements
Module: gru_hidden_update

Interface
REQ-001 The block SHALL have parameter INT_WIDTH, default 8, integer bits of the signed fixed-point format.
REQ-002 The block SHALL have parameter FRAC_WIDTH, default 8, fractional bits (ONE = 1<<FRAC_WIDTH).
REQ-003 The block SHALL have parameter WIDTH, default INT_WIDTH+FRAC_WIDTH+1, data word width.
REQ-004 The block SHALL have parameter HIDDEN, default 16, hidden-state elements per timestep; legal range >= 2.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 Port list:
 clk        in   1      rising-edge clock
 reset_n    in   1      async active-low reset
 h_clear    in   1      sync pulse: zero stored hidden state, restart sequence
 in_valid   in   1      element offered
 in_ready   out  1      element accepted when in_valid && in_ready
 in_z       in   WIDTH  update gate z_i (sigmoid output)
 in_n       in   WIDTH  candidate n_i (tanh output)
 out_valid  out  1      result held
 out_ready  in   1      consumer accepts when out_valid && out_ready
 out_h      out  WIDTH  new hidden element h_i
 out_idx    out  $clog2(HIDDEN)  element index of out_h
 out_last   out  1      out_idx == HIDDEN-1

Function
REQ-007 The block SHALL store HIDDEN signed WIDTH-bit entries h[0..HIDDEN-1], all zero after reset or h_clear.
REQ-008 The block SHALL accept elements in order; an index counter SHALL start at 0, increment per accepted element, and wrap HIDDEN-1 -> 0.
REQ-009 The block SHALL compute h_new = sat_add(n, fx_mult(z, sat_sub(h_old, n))), i.e. (1-z)*n + z*h_old.
REQ-010 fx_mult SHALL form the full 2*WIDTH product, shift right FRAC_WIDTH, add product bit FRAC_WIDTH-1 (round half up), and saturate to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1].
REQ-011 sat_add/sat_sub SHALL use a WIDTH+1 intermediate and saturate to the same range.
REQ-012 The pipeline SHALL have two stages: S1 registers sat_sub(h_old, n), z, n, idx; S2 registers out_h, out_idx, out_last.
REQ-013 Latency SHALL be 2 cycles from an accepted input to out_valid, absent backpressure; throughput one element/cycle.
REQ-014 h[idx] SHALL be written with h_new in the cycle S2 loads; HIDDEN >= 2 guarantees no read-after-write hazard.
REQ-015 The pipeline SHALL advance when !out_valid || out_ready; in_ready SHALL equal that advance condition and be 0 while h_clear is high.
REQ-016 While out_valid && !out_ready, out_h, out_idx, out_last SHALL hold stable.
REQ-017 h_clear SHALL in one cycle zero all h entries, reset the index to 0, invalidate S1 and S2 (out_valid=0) and discard any input offered that cycle.

Reset
REQ-018 While reset_n is low: in_ready=0, out_valid=0, out_h=0, out_idx=0, out_last=0, all h entries and the index SHALL be 0, both stages empty.
REQ-019 Reset assertion mid-sequence SHALL abort immediately; the first element after release SHALL be index 0.

Configuration
REQ-020 With GRU_HIDDEN_CLAMP_EN defined, in_z SHALL be clamped to [0, ONE] and in_n to [-ONE, ONE] before S1; without it, inputs are used unmodified.

Structure
REQ-021 Package gru_fx_pkg SHALL hold ONE, FX_MAX, FX_MIN constants and the fx_mult, sat_add, sat_sub functions, parameterised by WIDTH/FRAC_WIDTH.
REQ-022 Storage SHALL be sub-module gru_state_ram (HIDDEN x WIDTH, one async read port, one sync write port, synchronous clear).

Verification (Q8.8, ONE=256, HIDDEN=4)
REQ-023 Clear state, send z=0, n=100 on all 4 -> out_h=100 each, out_idx 0..3, out_last on idx 3, out_valid 2 cycles after each accept.
REQ-024 Following timestep z=256, n=-50 -> out_h=100 (old kept); then z=128, n=0 -> out_h=50.
REQ-025 h_old=65535, n=-65536, z=256 -> sat_sub saturates to 65535, out_h=-1.
REQ-026 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after pipeline fills, out_h stable, no element lost or duplicated.
REQ-027 Pulse h_clear after index 2 -> out_valid=0 next cycle, next element is idx 0 with h_old=0.
REQ-028 z=512, n=0, h_old=100: with GRU_HIDDEN_CLAMP_EN out_h=100; without out_h=200.

Source files
------------

// File: rtl/gru_fx_pkg.sv
// Signed fixed-point helpers for the GRU hidden-state update.
// Arithmetic is done in a 64-bit signed container and then saturated to a
// caller-supplied word width. Supports word widths up to 32 bits and
// FRAC_WIDTH >= 1.
package gru_fx_pkg;

    typedef logic signed [63:0] fx_wide_t;

    // Default Q8.8 format: 8 integer bits, 8 fraction bits, 1 sign bit
    localparam int       FX_INT_W  = 8;
    localparam int       FX_FRAC_W = 8;
    localparam int       FX_W      = FX_INT_W + FX_FRAC_W + 1;
    localparam fx_wide_t ONE       = 64'sd1 <<< FX_FRAC_W;
    localparam fx_wide_t FX_MAX    = (64'sd1 <<< (FX_W - 1)) - 64'sd1;
    localparam fx_wide_t FX_MIN    = -(64'sd1 <<< (FX_W - 1));

    function automatic fx_wide_t fx_one(input int frac_w);
        return 64'sd1 <<< frac_w;
    endfunction

    function automatic fx_wide_t fx_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic fx_wide_t fx_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic fx_wide_t fx_clamp(input fx_wide_t v, input fx_wide_t lo,
                                          input fx_wide_t hi);
        fx_wide_t r;
        r = v;
        if (v > hi) r = hi;
        else if (v < lo) r = lo;
        return r;
    endfunction

    function automatic fx_wide_t fx_sat(input fx_wide_t v, input int w);
        return fx_clamp(v, fx_min(w), fx_max(w));
    endfunction

    // Full product, drop FRAC bits, round half up using the highest dropped bit
    function automatic fx_wide_t fx_mult(input fx_wide_t a, input fx_wide_t b,
                                         input int w, input int frac_w);
        fx_wide_t p;
        fx_wide_t r;
        p = a * b;
        r = (p >>> frac_w) + ((p >>> (frac_w - 1)) & 64'sd1);
        return fx_sat(r, w);
    endfunction

    function automatic fx_wide_t sat_add(input fx_wide_t a, input fx_wide_t b, input int w);
        return fx_sat(a + b, w);
    endfunction

    function automatic fx_wide_t sat_sub(input fx_wide_t a, input fx_wide_t b, input int w);
        return fx_sat(a - b, w);
    endfunction

endpackage

// File: rtl/gru_state_ram.sv
// Hidden-state storage: DEPTH x WIDTH, async read, sync write, sync clear.
module gru_state_ram #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;

    assign o_rdata = r_mem[i_raddr];

    // Clear wins over a same-cycle write so a cleared timestep starts from zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    r_mem <= '0;
        else if (i_clr)  r_mem <= '0;
        else if (i_we)   r_mem[i_waddr] <= i_wdata;
    end

endmodule

// File: rtl/gru_hidden_update.sv
// GRU hidden-state update: h_new = (1-z)*n + z*h_old, one element per cycle,
// two pipeline stages. Define GRU_HIDDEN_CLAMP_EN to clamp z to [0,ONE] and
// n to [-ONE,ONE] before the first stage.
module gru_hidden_update
    import gru_fx_pkg::*;
#(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 8,
    parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1,
    parameter int HIDDEN     = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      h_clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_z,
    input  logic [WIDTH-1:0]          in_n,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_h,
    output logic [$clog2(HIDDEN)-1:0] out_idx,
    output logic                      out_last
);

    localparam int            AW       = $clog2(HIDDEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(HIDDEN - 1);

    logic             r_run;
    logic [AW-1:0]    r_idx;
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_d, r_s1_z, r_s1_n;
    logic [AW-1:0]    r_s1_idx;
    logic             r_s2_vld;
    logic [WIDTH-1:0] r_s2_h;
    logic [AW-1:0]    r_s2_idx;
    logic             r_s2_last;

    logic             w_adv, w_acc, w_we;
    logic [WIDTH-1:0] w_z, w_n, w_h_old, w_d, w_h_new;

    // Whole pipeline moves as one; a stalled output freezes both stages
    assign w_adv    = !r_s2_vld || out_ready;
    assign in_ready = r_run && w_adv && !h_clear;
    assign w_acc    = in_valid && in_ready;

`ifdef GRU_HIDDEN_CLAMP_EN
    assign w_z = WIDTH'(fx_clamp(fx_wide_t'($signed(in_z)), 64'sd0, fx_one(FRAC_WIDTH)));
    assign w_n = WIDTH'(fx_clamp(fx_wide_t'($signed(in_n)), -fx_one(FRAC_WIDTH),
                                 fx_one(FRAC_WIDTH)));
`else
    assign w_z = in_z;
    assign w_n = in_n;
`endif

    assign w_d     = WIDTH'(sat_sub(fx_wide_t'($signed(w_h_old)), fx_wide_t'($signed(w_n)), WIDTH));
    assign w_h_new = WIDTH'(sat_add(fx_wide_t'($signed(r_s1_n)),
                                    fx_mult(fx_wide_t'($signed(r_s1_z)),
                                            fx_wide_t'($signed(r_s1_d)), WIDTH, FRAC_WIDTH),
                                    WIDTH));

    // State is written back as the result enters S2; the next read of the same
    // index is at least HIDDEN accepts later, so no forwarding is needed
    assign w_we = w_adv && r_s1_vld && !h_clear;

    gru_state_ram #(
        .WIDTH (WIDTH),
        .DEPTH (HIDDEN),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (h_clear),
        .i_we    (w_we),
        .i_waddr (r_s1_idx),
        .i_wdata (w_h_new),
        .i_raddr (r_idx),
        .o_rdata (w_h_old)
    );

    // Hold off input for the first cycle after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_run <= 1'b0;
        else          r_run <= 1'b1;
    end

    // S1: capture h_old - n plus operands, advance the element index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx    <= '0;
            r_s1_vld <= 1'b0;
            r_s1_d   <= '0;
            r_s1_z   <= '0;
            r_s1_n   <= '0;
            r_s1_idx <= '0;
        end else if (h_clear) begin
            r_idx    <= '0;
            r_s1_vld <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld <= w_acc;
            if (w_acc) begin
                r_s1_d   <= w_d;
                r_s1_z   <= w_z;
                r_s1_n   <= w_n;
                r_s1_idx <= r_idx;
                r_idx    <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // S2: output register, held while the consumer stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_h    <= '0;
            r_s2_idx  <= '0;
            r_s2_last <= 1'b0;
        end else if (h_clear) begin
            r_s2_vld  <= 1'b0;
        end else if (w_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_h    <= w_h_new;
                r_s2_idx  <= r_s1_idx;
                r_s2_last <= (r_s1_idx == LAST_IDX);
            end
        end
    end

    assign out_valid = r_s2_vld;
    assign out_h     = r_s2_h;
    assign out_idx   = r_s2_idx;
    assign out_last  = r_s2_last;

endmodule

// File: tb/tb_gru_hidden_update.sv
// Directed bench for gru_hidden_update (Q8.8, HIDDEN=4) with a scoreboard queue.
module tb_gru_hidden_update;

    localparam int     W     = 17;
    localparam int     HID   = 4;
    localparam longint VMAX  = 65535;
    localparam longint VMIN  = -65536;
    localparam longint ONE   = 256;
    localparam longint NOEXP = 64'sd1 <<< 40;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         h_clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready, out_valid, out_last;
    logic [W-1:0] in_z = '0;
    logic [W-1:0] in_n = '0;
    logic [W-1:0] out_h;
    logic [1:0]   out_idx;

    typedef struct {
        longint h;
        int     idx;
        bit     last;
    } exp_t;

    exp_t   exp_q[$];
    longint mdl_h[HID];
    int     mdl_idx = 0;
    longint cur_exp = NOEXP;
    int     n_cmp = 0;
    int     n_err = 0;

    bit     prev_stall = 1'b0;
    longint prev_h;
    int     prev_idx;
    bit     prev_last;

    always #5 clk = ~clk;

    gru_hidden_update #(
        .INT_WIDTH (8),
        .FRAC_WIDTH(8),
        .WIDTH     (W),
        .HIDDEN    (HID)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .h_clear   (h_clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_z      (in_z),
        .in_n      (in_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_h     (out_h),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference arithmetic, written independently of the RTL helpers
    function automatic longint m_sat(input longint v);
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return v;
    endfunction

    function automatic longint m_mul(input longint a, input longint b);
        return m_sat((a * b + 128) >>> 8);
    endfunction

    function automatic longint m_lim(input longint v, input longint lo, input longint hi);
`ifdef GRU_HIDDEN_CLAMP_EN
        if (v > hi) return hi;
        if (v < lo) return lo;
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HID; i++) mdl_h[i] = 0;
        mdl_idx = 0;
        exp_q.delete();
    endtask

    task automatic model_accept();
        longint z, n, ho, hn;
        z  = m_lim(longint'($signed(in_z)), 0, ONE);
        n  = m_lim(longint'($signed(in_n)), -ONE, ONE);
        ho = mdl_h[mdl_idx];
        hn = (cur_exp != NOEXP) ? cur_exp : m_sat(n + m_mul(z, m_sat(ho - n)));
        exp_q.push_back('{h: hn, idx: mdl_idx, last: (mdl_idx == HID - 1)});
        mdl_h[mdl_idx] = hn;
        mdl_idx = (mdl_idx + 1) % HID;
    endtask

    // One clock: note acceptance before the edge, then step past it
    task automatic step(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) model_accept();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input longint z, input longint n, input longint e);
        bit acc;
        int t;
        in_z = W'(z);
        in_n = W'(n);
        in_valid = 1'b1;
        cur_exp = e;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 50) begin
            step(acc);
            t++;
        end
        if (!acc) chk("accept_timeout", 32'(acc), 1);
        in_valid = 1'b0;
        cur_exp = NOEXP;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_empty", 32'(exp_q.size()), 0);
    endtask

    // Clear with an input offered in the same cycle; that input must be dropped
    task automatic do_clear();
        h_clear  = 1'b1;
        in_valid = 1'b1;
        in_z     = W'(64'sd0);
        in_n     = W'(64'sd99);
        @(negedge clk);
        chk("clr_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        h_clear  = 1'b0;
        in_valid = 1'b0;
        model_reset();
        chk("clr_out_valid", 32'(out_valid), 0);
    endtask

    // Output monitor: scoreboard pop on handshake, stability check while stalled
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_h", $signed(out_h), 32'(prev_h));
                chk("hold_idx", 32'(out_idx), prev_idx);
                chk("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(exp_q.size()), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_h", $signed(out_h), 32'(e.h));
                    chk("out_idx", 32'(out_idx), e.idx);
                    chk("out_last", 32'(out_last), 32'(e.last));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_h     = longint'($signed(out_h));
            prev_idx   = int'(out_idx);
            prev_last  = out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int k, t;
        longint sz[6], sn[6];
        sz = '{0, 128, 256, 64, 200, 32};
        sn = '{100, -40, 30, -200, 77, 500};

        // Reset state
        model_reset();
        #12;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_h", $signed(out_h), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_out_last", 32'(out_last), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // z=0, n=100 across a timestep; latency check on the first two elements
        do_clear();
        send(0, 100, 100);
        chk("lat_first_not_yet", 32'(out_valid), 0);
        send(0, 100, 100);
        chk("lat_first_valid", 32'(out_valid), 1);
        send(0, 100, 100);
        send(0, 100, 100);
        drain();

        // z=ONE keeps old state; z=ONE/2, n=0 halves it
        for (int i = 0; i < HID; i++) send(256, -50, 100);
        for (int i = 0; i < HID; i++) send(128, 0, 50);
        drain();

        // Saturating subtract: h_old=max, n=min
`ifdef GRU_HIDDEN_CLAMP_EN
        send(0, 65535, 256);
`else
        send(0, 65535, 65535);
`endif
        for (int i = 1; i < HID; i++) send(0, 0, 0);
`ifdef GRU_HIDDEN_CLAMP_EN
        send(256, -65536, 256);
`else
        send(256, -65536, -1);
`endif
        drain();

        // Backpressure: stall 5 cycles with input pending, then release
        do_clear();
        out_ready = 1'b0;
        k = 0;
        in_z = W'(sz[0]);
        in_n = W'(sn[0]);
        in_valid = 1'b1;
        repeat (5) begin
            step(acc);
            if (acc) begin
                k++;
                in_z = W'(sz[k]);
                in_n = W'(sn[k]);
            end
        end
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_accepted", k, 2);
        out_ready = 1'b1;
        t = 0;
        while (k < 6 && t < 50) begin
            step(acc);
            if (acc) begin
                k++;
                if (k < 6) begin
                    in_z = W'(sz[k]);
                    in_n = W'(sn[k]);
                end
            end
            t++;
        end
        in_valid = 1'b0;
        chk("stall_all_sent", k, 6);
        drain();

        // Clear right after index 2 is accepted
        do_clear();
        send(64, 300, NOEXP);
        send(64, 300, NOEXP);
        send(64, 300, NOEXP);
        do_clear();
        send(256, 7, 0);
        drain();

        // z above ONE: clamped vs passed through
        do_clear();
        send(0, 100, 100);
        for (int i = 1; i < HID; i++) send(0, 0, 0);
`ifdef GRU_HIDDEN_CLAMP_EN
        send(512, 0, 100);
`else
        send(512, 0, 200);
`endif
        drain();

        // Reset mid-sequence: aborts at once, restarts at index 0 with zero state
        send(0, 40, 40);
        send(0, 40, 40);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_out_h", $signed(out_h), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(256, 7, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
